variable_table_writer: RTL
==========================

Name: variable_table_writer

Overview:
- Write-side controller for the replicated variable-assignment tables.
- Each clause evaluator holds private copies of the assignment; this block keeps every copy coherent.
- Performs two operations, one at a time:
  - Initial assignment sweep: writes all variables into every table.
  - Single-variable flip: reads the current value from table copy 0 port A, then writes the inverted value into every copy through port B in one cycle.
- Sits directly upstream of the variable table cluster's port-B (write) inputs and table 0's port-A read path.

Parameters:
- LITERAL_ADDRESS_WIDTH, 11, width of the variable address.
- CLUSTER_SIZE, 40, number of table copies driven; equals 2 per clause evaluator.
- NUM_VARIABLES, 2048, number of valid addresses (0..NUM_VARIABLES-1). Must satisfy NUM_VARIABLES <= 2**LITERAL_ADDRESS_WIDTH.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- init_start  in  1  pulse; start the assignment sweep.
- init_done  out  1  one-cycle pulse on the last sweep write.
- flip_valid  in  1  flip request.
- flip_ready  out  1  block can accept a flip.
- flip_addr  in  LITERAL_ADDRESS_WIDTH  variable to flip.
- flip_done  out  1  one-cycle pulse in the write cycle of a flip.
- flip_err  out  1  one-cycle pulse; flip address out of range, request dropped.
- new_value  out  1  value written by the flip; valid while flip_done is high.
- busy  out  1  high in any state other than IDLE; evaluators must not rely on table reads while busy.
- rd_en  out  1  table 0 port-A enable.
- rd_addr  out  LITERAL_ADDRESS_WIDTH  table 0 port-A address.
- rd_data  in  1  table 0 port-A data; valid one cycle after rd_en.
- en_b  out  CLUSTER_SIZE  port-B enables, all bits equal.
- we_b  out  CLUSTER_SIZE  port-B write enables, all bits equal.
- addr_b  out  LITERAL_ADDRESS_WIDTH*CLUSTER_SIZE  same address replicated into each slice.
- din_b  out  CLUSTER_SIZE  same data bit replicated.

Behaviour:
- Reset: state=IDLE. All outputs are 0 except flip_ready, which is 1 from the first cycle after reset deasserts. The sweep counter clears to 0.
- Reset mid-operation aborts the operation. A partial sweep or flip is not resumed, and no done pulse is issued.
- States: IDLE, INIT, FLIP_RD, FLIP_WR.
- flip_ready = (state==IDLE) && !init_start. This is combinational.
- IDLE -> INIT on init_start. init_start has priority over flip_valid in the same cycle.
- INIT:
  - Drives en_b=we_b=all ones, addr_b={CLUSTER_SIZE{cnt}}, din_b={CLUSTER_SIZE{init_bit}}.
  - cnt increments by 1 each cycle, so the sweep takes exactly NUM_VARIABLES cycles.
  - On cnt==NUM_VARIABLES-1: init_done=1, cnt clears, next state IDLE.
  - init_start and flip_valid are ignored in INIT.
- Flip handshake at cycle N (flip_valid && flip_ready):
  - If flip_addr >= NUM_VARIABLES: flip_err=1 at N+1, state stays IDLE, no table access.
  - Otherwise the address is latched; N+1 FLIP_RD.
- FLIP_RD (N+1): rd_en=1, rd_addr=latched address; next state FLIP_WR.
- FLIP_WR (N+2):
  - en_b=we_b=all ones, addr_b=replicated latched address, din_b=replicated ~rd_data.
  - flip_done=1, new_value=~rd_data.
  - Next state IDLE; flip_ready returns high at N+3.
- Throughput: one flip every 3 cycles at best. Table contents are updated at the N+3 clock edge.
- A back-to-back flip of the same address reads the updated value, because its read occurs at N+4 or later.
- Outputs not listed for a state are driven to 0, so en_b=0 outside INIT and FLIP_WR.

Optional Feature:
- VAR_TABLE_WRITER_INIT_LFSR_EN defined:
  - init_bit is bit 0 of a 16-bit Fibonacci LFSR, taps 16,14,13,11, reset seed 16'hACE1.
  - The LFSR advances once per INIT cycle and holds otherwise.
- Undefined: init_bit=0, giving an all-false initial assignment, and no LFSR logic is built.

Decomposition:
- Shared package vt_pkg holds:
  - the state enum (IDLE/INIT/FLIP_RD/FLIP_WR);
  - default LITERAL_ADDRESS_WIDTH and CLUSTER_SIZE constants;
  - LFSR seed and tap constants.
- One sub-module is natural: vt_lfsr16 (enable, synchronous reset, seed parameter), instantiated only under VAR_TABLE_WRITER_INIT_LFSR_EN.
- The fan-out replication stays in the top module.

Test Plan:
Bench setup: LITERAL_ADDRESS_WIDTH=3, CLUSTER_SIZE=4, NUM_VARIABLES=6, with a behavioural table model.
1. Reset held for 3 cycles, then released -> all outputs 0; flip_ready=1 one cycle after release.
2. init_start pulse, LFSR off -> 6 consecutive cycles with we_b=4'b1111 and addr_b slices 0..5; init_done at the 6th; every copy reads 0 at addresses 0..5.
3. flip_addr=3, table bit=0, handshake at cycle N -> rd_en/rd_addr=3 at N+1; at N+2 din_b=4'b1111 and flip_done=1 with new_value=1; flip_ready=1 at N+3; all copies hold 1 at address 3.
4. Two back-to-back flips of address 3 -> second new_value=0; all copies return to 0.
5. flip_addr=7 -> flip_err pulse at N+1; no rd_en or we_b activity; state stays IDLE.
6. init_start and flip_valid together -> flip_ready=0 and INIT runs. Separately, rst asserted mid-INIT at cnt=2 -> next cycle en_b=0, busy=0, and no init_done pulse.

Source files
------------

// File: rtl/vt_pkg.sv
// Shared types and constants for the variable table writer.
package vt_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    INIT    = 2'd1,
    FLIP_RD = 2'd2,
    FLIP_WR = 2'd3
  } vt_state_e;

  localparam int LIT_ADDR_W_DEF    = 11;
  localparam int CLUSTER_SIZE_DEF  = 40;
  localparam int NUM_VARIABLES_DEF = 2048;

  // Fibonacci taps 16,14,13,11 expressed as a mask over bits [15:0]
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/vt_lfsr16.sv
// 16-bit Fibonacci LFSR used to seed a pseudo-random initial assignment.
// Only built when VAR_TABLE_WRITER_INIT_LFSR_EN is defined.
`ifdef VAR_TABLE_WRITER_INIT_LFSR_EN
module vt_lfsr16
  import vt_pkg::*;
#(
  parameter logic [15:0] SEED = LFSR_SEED
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  output logic bit_o
);

  logic [15:0] lfsr_q;

  always_ff @(posedge clk) begin
    if (rst)       lfsr_q <= SEED;
    else if (en_i) lfsr_q <= {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
  end

  assign bit_o = lfsr_q[0];

endmodule
`endif

// File: rtl/variable_table_writer.sv
// Write-side controller keeping all replicated variable-table copies coherent.
// Optional VAR_TABLE_WRITER_INIT_LFSR_EN: pseudo-random initial assignment.
module variable_table_writer
  import vt_pkg::*;
#(
  parameter int LITERAL_ADDRESS_WIDTH = LIT_ADDR_W_DEF,
  parameter int CLUSTER_SIZE          = CLUSTER_SIZE_DEF,
  parameter int NUM_VARIABLES         = NUM_VARIABLES_DEF
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        init_start,
  output logic                                        init_done,
  input  logic                                        flip_valid,
  output logic                                        flip_ready,
  input  logic [LITERAL_ADDRESS_WIDTH-1:0]            flip_addr,
  output logic                                        flip_done,
  output logic                                        flip_err,
  output logic                                        new_value,
  output logic                                        busy,
  output logic                                        rd_en,
  output logic [LITERAL_ADDRESS_WIDTH-1:0]            rd_addr,
  input  logic                                        rd_data,
  output logic [CLUSTER_SIZE-1:0]                     en_b,
  output logic [CLUSTER_SIZE-1:0]                     we_b,
  output logic [LITERAL_ADDRESS_WIDTH*CLUSTER_SIZE-1:0] addr_b,
  output logic [CLUSTER_SIZE-1:0]                     din_b
);

  localparam int              AW   = LITERAL_ADDRESS_WIDTH;
  localparam logic [AW-1:0]   LAST = AW'(NUM_VARIABLES - 1);

  vt_state_e     state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          err_q, err_d;
  logic          init_bit, flip_req, addr_ok;
  logic          wr_en, wr_bit;
  logic [AW-1:0] wr_addr;

`ifdef VAR_TABLE_WRITER_INIT_LFSR_EN
  vt_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .en_i  (state_q == INIT),
    .bit_o (init_bit)
  );
`else
  assign init_bit = 1'b0;
`endif

  // init_start wins over a simultaneous flip, so ready drops combinationally
  assign flip_ready = (state_q == IDLE) && !init_start && !rst;
  assign flip_req   = flip_valid && flip_ready;
  assign addr_ok    = (32'(flip_addr) < 32'(NUM_VARIABLES));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (init_start) state_d = INIT;
        else if (flip_req) begin
          if (addr_ok) begin
            addr_d  = flip_addr;
            state_d = FLIP_RD;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      INIT: begin
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      FLIP_RD: state_d = FLIP_WR;
      FLIP_WR: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_en     = 1'b0;
    wr_addr   = '0;
    wr_bit    = 1'b0;
    rd_en     = 1'b0;
    rd_addr   = '0;
    init_done = 1'b0;
    flip_done = 1'b0;
    new_value = 1'b0;
    case (state_q)
      INIT: begin
        wr_en     = 1'b1;
        wr_addr   = cnt_q;
        wr_bit    = init_bit;
        init_done = (cnt_q == LAST);
      end
      FLIP_RD: begin
        rd_en   = 1'b1;
        rd_addr = addr_q;
      end
      FLIP_WR: begin
        wr_en     = 1'b1;
        wr_addr   = addr_q;
        wr_bit    = ~rd_data;
        flip_done = 1'b1;
        new_value = ~rd_data;
      end
      default: ;
    endcase
  end

  assign busy     = (state_q != IDLE);
  assign flip_err = err_q;
  assign en_b     = {CLUSTER_SIZE{wr_en}};
  assign we_b     = {CLUSTER_SIZE{wr_en}};
  assign addr_b   = {CLUSTER_SIZE{wr_addr}};
  assign din_b    = {CLUSTER_SIZE{wr_bit}};

endmodule
